seg7_scan_driver: RTL

//  Time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits. Accepts a packed

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/seg7_decoder.sv | 14 +
 rtl/seg7_scan_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment types, segment patterns and the nibble decode
// function used by the scan driver. Bit order is {a,b,c,d,e,f,g}; 1 = lit.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b1111110;
  localparam seg7_t SEG_1     = 7'b0110000;
  localparam seg7_t SEG_2     = 7'b1101101;
  localparam seg7_t SEG_3     = 7'b1111001;
  localparam seg7_t SEG_4     = 7'b0110011;
  localparam seg7_t SEG_5     = 7'b1011011;
  localparam seg7_t SEG_6     = 7'b1011111;
  localparam seg7_t SEG_7     = 7'b1110000;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1111011;
  localparam seg7_t SEG_A     = 7'b1110111;
  localparam seg7_t SEG_B     = 7'b0011111;
  localparam seg7_t SEG_C     = 7'b1001110;
  localparam seg7_t SEG_D     = 7'b0111101;
  localparam seg7_t SEG_E     = 7'b1001111;
  localparam seg7_t SEG_F     = 7'b1000111;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Codes 10-15 show A,b,C,d,E,F only when hex_en is set; otherwise blank.
  function automatic seg7_t seg7_decode(input logic [3:0] nibble, input logic hex_en);
    seg7_t v_seg;
    case (nibble)
      4'd0:    v_seg = SEG_0;
      4'd1:    v_seg = SEG_1;
      4'd2:    v_seg = SEG_2;
      4'd3:    v_seg = SEG_3;
      4'd4:    v_seg = SEG_4;
      4'd5:    v_seg = SEG_5;
      4'd6:    v_seg = SEG_6;
      4'd7:    v_seg = SEG_7;
      4'd8:    v_seg = SEG_8;
      4'd9:    v_seg = SEG_9;
      4'd10:   v_seg = hex_en ? SEG_A : SEG_BLANK;
      4'd11:   v_seg = hex_en ? SEG_B : SEG_BLANK;
      4'd12:   v_seg = hex_en ? SEG_C : SEG_BLANK;
      4'd13:   v_seg = hex_en ? SEG_D : SEG_BLANK;
      4'd14:   v_seg = hex_en ? SEG_E : SEG_BLANK;
      default: v_seg = hex_en ? SEG_F : SEG_BLANK;
    endcase
    return v_seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational nibble -> segment pattern. HEX_EN selects
// whether codes 10-15 render as letters or stay blank.
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  assign o_seg = seg7_decode(i_nibble, HEX_EN != 0);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS 7-segment digits.
// A loaded value is parked in a shadow buffer and promoted to the displayed
// (active) value only at a frame boundary, so a frame never mixes two values.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the highest
// nonzero nibble of the active value (digit 0 is always shown).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int HEX_EN     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           r_scan_cnt;
  logic [DW-1:0]           r_dig_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;

  logic                    w_scan_wrap;
  logic                    w_last_dig;
  logic                    w_boundary;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_blank_vec;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_next;
  seg7_t                   w_seg_dec;

  assign w_scan_wrap = (r_scan_cnt == CW'(SCAN_DIV - 1));
  assign w_last_dig  = (r_dig_idx == DW'(NUM_DIGITS - 1));
  assign w_boundary  = w_scan_wrap && w_last_dig;

  // Slot timer and digit index; the index only moves when the slot timer wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= '0;
    end else if (w_scan_wrap) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= w_last_dig ? '0 : r_dig_idx + DW'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  // Double buffer: a load coinciding with the boundary bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= data_in;
      end
      if (w_boundary) begin
        if (load) begin
          r_active <= data_in;
        end else if (pending) begin
          r_active <= r_shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Select the nibble and one-hot enable for the digit currently being scanned.
  always_comb begin
    w_nibble  = '0;
    w_an_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_dig_idx == DW'(i)) begin
        w_nibble     = r_active[4*i +: 4];
        w_an_next[i] = 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i is blank when it and every digit above it are zero.
  always_comb begin
    logic v_any_nz;
    v_any_nz    = 1'b0;
    w_blank_vec = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_any_nz       = v_any_nz | (|r_active[4*i +: 4]);
      w_blank_vec[i] = ~v_any_nz;
    end
`else
    v_any_nz = 1'b0;
`endif
    w_blank = |(w_blank_vec & w_an_next);
  end

  seg7_decoder #(
    .HEX_EN (HEX_EN)
  ) u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  // Registered pin drive: outputs reflect the index/value of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= w_blank ? SEG_BLANK : w_seg_dec;
      an         <= w_an_next;
      frame_done <= w_boundary;
    end
  end

endmodule
